life_cell_engine: RTL and testbench



---
 rtl/life_pkg.sv | 18 +
 rtl/nbr_popcount.sv | 21 ++
 rtl/life_cell_engine.sv | 106 ++++++++++
 tb/tb_life_cell_engine.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/life_pkg.sv
// Shared definitions for the Game-of-Life cell: default Conway rule masks,
// the generation state encoding and the neighbour-count width helper.
package life_pkg;

  localparam logic [8:0] LIFE_BIRTH_DEFAULT   = 9'b0_0000_1000;
  localparam logic [8:0] LIFE_SURVIVE_DEFAULT = 9'b0_0000_1100;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } life_state_t;

  // Bits needed to hold a count of 0..n inclusive.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/nbr_popcount.sv
// Combinational population count of the NBR neighbour-alive bits.
// Output is zero-extended to cnt_width(NBR) bits; it can never overflow.
module nbr_popcount
  import life_pkg::*;
#(
  parameter int NBR = 8
) (
  input  logic [NBR-1:0]            nbrs,
  output logic [cnt_width(NBR)-1:0] cnt
);

  localparam int CW = cnt_width(NBR);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < NBR; i++) begin
      cnt = cnt + CW'(nbrs[i]);
    end
  end

endmodule

// File: rtl/life_cell_engine.sv
// One Game-of-Life board cell: step -> count -> rule evaluation, 2-cycle step-to-done.
// Optional saturating survival-age counter built only when LIFE_CELL_AGE_EN is defined.
module life_cell_engine
  import life_pkg::*;
#(
  parameter int           NBR          = 8,
  parameter logic [NBR:0] BIRTH_MASK   = LIFE_BIRTH_DEFAULT,
  parameter logic [NBR:0] SURVIVE_MASK = LIFE_SURVIVE_DEFAULT,
  parameter int           AW           = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      seed_valid,
  input  logic                      seed_val,
  input  logic                      step,
  input  logic [NBR-1:0]            nbrs,
  output logic                      alive,
  output logic [cnt_width(NBR)-1:0] count,
  output logic                      busy,
  output logic                      done,
  output logic                      changed,
  output logic [AW-1:0]             age
);

  localparam int CW = cnt_width(NBR);

  life_state_t   state, state_nxt;
  logic [CW-1:0] pop;
  logic          next_alive;
  logic          capture;
  logic          evaluate;

  nbr_popcount #(.NBR(NBR)) u_popcount (
    .nbrs (nbrs),
    .cnt  (pop)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Seeding wins in every state; a step arriving while busy is simply dropped.
  always_comb begin
    state_nxt = state;
    if (seed_valid) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (step) state_nxt = COUNT;
        COUNT:   state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    busy       = (state == COUNT);
    capture    = (state == IDLE) && step && !seed_valid;
    evaluate   = (state == COUNT) && !seed_valid;
    next_alive = alive ? SURVIVE_MASK[count] : BIRTH_MASK[count];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      alive   <= 1'b0;
      count   <= '0;
      done    <= 1'b0;
      changed <= 1'b0;
    end else begin
      done <= 1'b0;
      if (seed_valid) begin
        alive   <= seed_val;
        changed <= seed_val ^ alive;
      end else if (capture) begin
        count <= pop;
      end else if (evaluate) begin
        alive   <= next_alive;
        changed <= next_alive ^ alive;
        done    <= 1'b1;
      end
    end
  end

`ifdef LIFE_CELL_AGE_EN
  logic [AW-1:0] age_q;

  // Age grows only on alive->alive generations; birth, death and seeding restart it.
  always_ff @(posedge clk) begin
    if (reset || seed_valid) begin
      age_q <= '0;
    end else if (evaluate) begin
      if (alive && next_alive) begin
        if (age_q != {AW{1'b1}}) age_q <= age_q + 1'b1;
      end else begin
        age_q <= '0;
      end
    end
  end

  assign age = age_q;
`else
  assign age = '0;
`endif

endmodule

// File: tb/tb_life_cell_engine.sv
// Directed bench for life_cell_engine: step expectations go to a scoreboard queue
// and are checked by a monitor on every done pulse; seeds and aborts are checked inline.
module tb_life_cell_engine;

  logic       clk = 1'b0;
  logic       reset;
  logic       seed_valid;
  logic       seed_val;
  logic       step;
  logic [7:0] nbrs;
  logic       alive;
  logic [3:0] count;
  logic       busy;
  logic       done;
  logic       changed;
  logic [1:0] age;

`ifdef LIFE_CELL_AGE_EN
  localparam bit AGE_EN = 1'b1;
`else
  localparam bit AGE_EN = 1'b0;
`endif

  typedef struct {
    logic [3:0] cnt;
    logic       alv;
    logic       chg;
    logic [1:0] ag;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  life_cell_engine #(.NBR(8), .AW(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .seed_valid (seed_valid),
    .seed_val   (seed_val),
    .step       (step),
    .nbrs       (nbrs),
    .alive      (alive),
    .count      (count),
    .busy       (busy),
    .done       (done),
    .changed    (changed),
    .age        (age)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] ea(input logic [1:0] v);
    return AGE_EN ? v : 2'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a step and queue its expected outcome; checks count/busy at t+1 and busy at t+2.
  task automatic do_step(input logic [7:0] nb, input logic [3:0] c, input logic a,
                         input logic ch, input logic [1:0] ag);
    exp_t e;
    e.cnt = c; e.alv = a; e.chg = ch; e.ag = ag;
    sbq.push_back(e);
    nbrs = nb;
    step = 1'b1;
    tick();
    step = 1'b0;
    chk("busy_t1", {7'd0, busy}, 8'd1);
    chk("count_t1", {4'd0, count}, {4'd0, c});
    tick();
    chk("busy_t2", {7'd0, busy}, 8'd0);
  endtask

  task automatic do_seed(input logic v, input logic exp_chg);
    seed_valid = 1'b1;
    seed_val   = v;
    tick();
    seed_valid = 1'b0;
    chk("seed_alive", {7'd0, alive}, {7'd0, v});
    chk("seed_changed", {7'd0, changed}, {7'd0, exp_chg});
    chk("seed_age", {6'd0, age}, 8'd0);
    chk("seed_done", {7'd0, done}, 8'd0);
  endtask

  // Scoreboard monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && done === 1'b1) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: done=1 with no step outstanding (t=%0t)", $time);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("done_alive", {7'd0, alive}, {7'd0, e.alv});
        chk("done_changed", {7'd0, changed}, {7'd0, e.chg});
        chk("done_age", {6'd0, age}, {6'd0, e.ag});
        chk("done_count", {4'd0, count}, {4'd0, e.cnt});
      end
    end
  end

  initial begin
    reset = 1'b1; seed_valid = 1'b0; seed_val = 1'b0; step = 1'b0; nbrs = '0;
    tick(); tick();
    reset = 1'b0;
    repeat (5) tick();
    chk("rst_alive", {7'd0, alive}, 8'd0);
    chk("rst_count", {4'd0, count}, 8'd0);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_done", {7'd0, done}, 8'd0);
    chk("rst_changed", {7'd0, changed}, 8'd0);
    chk("rst_age", {6'd0, age}, 8'd0);

    // Live cell with 2 neighbours survives.
    do_seed(1'b1, 1'b1);
    do_step(8'b0000_0110, 4'd2, 1'b1, 1'b0, ea(2'd1));

    // Dead cell with 3 neighbours is born; then 4 neighbours kill it.
    do_seed(1'b0, 1'b1);
    do_step(8'b0001_0101, 4'd3, 1'b1, 1'b1, 2'd0);
    do_step(8'b0000_1111, 4'd4, 1'b0, 1'b1, 2'd0);

    // Neighbours sampled at step time; a step while busy is ignored.
    begin
      exp_t e;
      e.cnt = 4'd3; e.alv = 1'b1; e.chg = 1'b1; e.ag = 2'd0;
      sbq.push_back(e);
      nbrs = 8'b0000_0111;
      step = 1'b1;
      tick();
      nbrs = 8'hFF;
      chk("busy_ignored_step", {7'd0, busy}, 8'd1);
      tick();
      step = 1'b0;
      chk("count_held", {4'd0, count}, 8'd3);
      repeat (3) tick();
      chk("no_requeue_busy", {7'd0, busy}, 8'd0);
    end

    // Five consecutive survivals: age saturates at 3 with a 2-bit counter.
    do_step(8'b0000_0011, 4'd2, 1'b1, 1'b0, ea(2'd1));
    do_step(8'b1000_0001, 4'd2, 1'b1, 1'b0, ea(2'd2));
    do_step(8'b0101_0100, 4'd3, 1'b1, 1'b0, ea(2'd3));
    do_step(8'b0011_0000, 4'd2, 1'b1, 1'b0, ea(2'd3));
    do_step(8'b1100_0001, 4'd3, 1'b1, 1'b0, ea(2'd3));

    // Seed mid-generation aborts it: no done, cell takes the seed value.
    nbrs = 8'b0000_0111;
    step = 1'b1;
    tick();
    step = 1'b0;
    seed_valid = 1'b1;
    seed_val = 1'b0;
    tick();
    seed_valid = 1'b0;
    chk("abort_alive", {7'd0, alive}, 8'd0);
    chk("abort_busy", {7'd0, busy}, 8'd0);
    chk("abort_changed", {7'd0, changed}, 8'd1);
    chk("abort_count", {4'd0, count}, 8'd3);
    chk("abort_age", {6'd0, age}, 8'd0);
    repeat (3) tick();

    // Reset mid-generation returns every output to its reset value.
    do_seed(1'b1, 1'b1);
    nbrs = 8'b0000_0011;
    step = 1'b1;
    tick();
    step = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rabort_alive", {7'd0, alive}, 8'd0);
    chk("rabort_count", {4'd0, count}, 8'd0);
    chk("rabort_busy", {7'd0, busy}, 8'd0);
    chk("rabort_done", {7'd0, done}, 8'd0);
    chk("rabort_changed", {7'd0, changed}, 8'd0);
    chk("rabort_age", {6'd0, age}, 8'd0);
    repeat (4) tick();

    chk("sb_drained", 8'(sbq.size()), 8'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
